// File: rtl/mem_arbiter.sv
// Purpose : shares one 64-bit burst memory port between the I-cache and the D-cache at 256-bit line granularity.
// Latency : grant edge, then one edge per accepted beat (4), then a one-cycle DONE response; back-to-back grants are 2 cycles apart.
// Backpr. : bmem_resp=0 stalls the burst with every output held; the caches hold their request until their resp pulse.
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   icache_read/address          I-cache line read request (held until icache_resp)
//   icache_rdata/resp            returned line and one-cycle completion pulse
//   dcache_read/write/address    D-cache line read or writeback request (held until dcache_resp)
//   dcache_wdata                 writeback line
//   dcache_rdata/resp            returned line and one-cycle completion pulse
//   bmem_read/write/address      burst command to memory, registered, constant for the whole burst
//   bmem_wdata                   current write beat
//   bmem_rdata/resp              current read beat / beat handshake from memory
module mem_arbiter #(
   parameter int LINE_W  = 256,
   parameter int BURST_W = 64,
   parameter int ADDR_W  = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                icache_read,
   input  logic [ADDR_W-1:0]   icache_address,
   output logic [LINE_W-1:0]   icache_rdata,
   output logic                icache_resp,
   input  logic                dcache_read,
   input  logic                dcache_write,
   input  logic [ADDR_W-1:0]   dcache_address,
   input  logic [LINE_W-1:0]   dcache_wdata,
   output logic [LINE_W-1:0]   dcache_rdata,
   output logic                dcache_resp,
   output logic                bmem_read,
   output logic                bmem_write,
   output logic [ADDR_W-1:0]   bmem_address,
   output logic [BURST_W-1:0]  bmem_wdata,
   input  logic [BURST_W-1:0]  bmem_rdata,
   input  logic                bmem_resp
);

   localparam int BEATS = LINE_W / BURST_W;
   localparam int CNT_W = $clog2(BEATS);
   // Clears the byte offset within a line so bursts are always line aligned.
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] RD_BURST = 2'd1;
   localparam logic [1:0] WR_BURST = 2'd2;
   localparam logic [1:0] DONE     = 2'd3;

   logic [1:0]         state;
   logic [CNT_W-1:0]   cnt;
   logic [LINE_W-1:0]  line_buf;
   logic               grant_d;   // 1: current transfer belongs to the D-cache
   logic               last_d;    // 1: D-cache won the most recent grant
   logic               pend_i;
   logic               pend_d;
   logic               pick_d;
   logic               last_beat;
   logic [ADDR_W-1:0]  addr_sel;

   assign pend_i    = icache_read;
   assign pend_d    = dcache_read | dcache_write;
   assign last_beat = (cnt == CNT_W'(BEATS - 1));

   // Round robin only matters on a tie: the side that did not win last time goes first.
   always_comb begin
      pick_d = pend_d;
      if (pend_i && pend_d) begin
         pick_d = ~last_d;
      end
   end

   assign addr_sel = pick_d ? dcache_address : icache_address;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         cnt          <= '0;
         line_buf     <= '0;
         grant_d      <= 1'b0;
         last_d       <= 1'b0;
         bmem_read    <= 1'b0;
         bmem_write   <= 1'b0;
         bmem_address <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pend_i || pend_d) begin
                  grant_d      <= pick_d;
                  last_d       <= pick_d;
                  cnt          <= '0;
                  bmem_address <= addr_sel & LINE_MASK;
                  // A write wins over a simultaneous (illegal) read on the D side.
                  if (pick_d && dcache_write) begin
                     line_buf   <= dcache_wdata;
                     bmem_write <= 1'b1;
                     state      <= WR_BURST;
                  end else begin
                     bmem_read  <= 1'b1;
                     state      <= RD_BURST;
                  end
               end
            end
            RD_BURST: begin
               if (bmem_resp) begin
                  line_buf[int'(cnt)*BURST_W +: BURST_W] <= bmem_rdata;
                  cnt <= cnt + 1'b1;
                  if (last_beat) begin
                     bmem_read <= 1'b0;
                     state     <= DONE;
                  end
               end
            end
            WR_BURST: begin
               if (bmem_resp) begin
                  cnt <= cnt + 1'b1;
                  if (last_beat) begin
                     bmem_write <= 1'b0;
                     state      <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Beat 0 is the lowest 64 bits of the line; the slice only follows cnt, so it is stable across wait states.
   assign bmem_wdata = (state == WR_BURST) ? line_buf[int'(cnt)*BURST_W +: BURST_W] : '0;

   // Both caches see the line buffer; the data is meaningful only while their resp is high.
   assign icache_rdata = line_buf;
   assign dcache_rdata = line_buf;
   assign icache_resp  = (state == DONE) && !grant_d;
   assign dcache_resp  = (state == DONE) &&  grant_d;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          icache_read = 1'b0;
   logic [31:0]   icache_address = '0;
   logic [255:0]  icache_rdata;
   logic          icache_resp;
   logic          dcache_read = 1'b0;
   logic          dcache_write = 1'b0;
   logic [31:0]   dcache_address = '0;
   logic [255:0]  dcache_wdata = '0;
   logic [255:0]  dcache_rdata;
   logic          dcache_resp;
   logic          bmem_read;
   logic          bmem_write;
   logic [31:0]   bmem_address;
   logic [63:0]   bmem_wdata;
   logic [63:0]   bmem_rdata = '0;
   logic          bmem_resp = 1'b0;

   mem_arbiter #(.LINE_W(256), .BURST_W(64), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .icache_read(icache_read), .icache_address(icache_address),
      .icache_rdata(icache_rdata), .icache_resp(icache_resp),
      .dcache_read(dcache_read), .dcache_write(dcache_write),
      .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
      .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
      .bmem_read(bmem_read), .bmem_write(bmem_write), .bmem_address(bmem_address),
      .bmem_wdata(bmem_wdata), .bmem_rdata(bmem_rdata), .bmem_resp(bmem_resp)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- memory device and reference contents ----------------
   logic [63:0]  mem [logic [31:0]];        // device contents, per beat byte address
   logic [255:0] ref_lines [logic [31:0]];  // expected contents, per line address
   bit           spurious = 1'b0;           // drive bmem_resp=1 whenever no burst is running
   int           waits = 0;                 // wait cycles inserted before every beat
   logic [31:0]  exp_baddr = '0;
   logic [255:0] exp_wline = '0;
   bit           last_ref = 1'b0;           // 1: D won the most recent grant

   function automatic logic [63:0] init_beat(input logic [31:0] a);
      return {a ^ 32'hA5A5_0F0F, ~a};
   endfunction

   function automatic logic [63:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return init_beat(a);
   endfunction

   function automatic logic [255:0] ref_line(input logic [31:0] la);
      logic [255:0] l;
      if (ref_lines.exists(la)) return ref_lines[la];
      for (int k = 0; k < 4; k++) l[64*k +: 64] = init_beat(la + 32'(8*k));
      return l;
   endfunction

   initial begin : mem_model
      int          beat = 0;
      int          wl = 0;
      bit          consumed = 1'b0;
      bit          was_wr = 1'b0;
      logic [63:0] wd_seen = '0;
      logic [31:0] addr_seen = '0;
      forever begin
         @(posedge clk);
         #2;
         if (consumed) begin
            if (was_wr) mem[addr_seen + 32'(8*beat)] = wd_seen;
            beat++;
            wl = waits;
         end
         consumed  = 1'b0;
         bmem_resp = 1'b0;
         if (!(bmem_read || bmem_write)) begin
            beat       = 0;
            wl         = waits;
            bmem_resp  = spurious;
            bmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
         end else begin
            check("bmem_rd_wr_exclusive", {bmem_read, bmem_write} == 2'b11, 1'b0);
            check("bmem_address", bmem_address, exp_baddr);
            if (beat > 3) begin
               check("burst_length", 256'(beat), 256'(3));
            end else begin
               if (bmem_write) check("bmem_wdata", bmem_wdata, exp_wline[64*beat +: 64]);
               if (wl > 0) begin
                  wl--;
               end else begin
                  bmem_resp  = 1'b1;
                  bmem_rdata = mem_rd(bmem_address + 32'(8*beat));
                  consumed   = 1'b1;
                  was_wr     = bmem_write;
                  wd_seen    = bmem_wdata;
                  addr_seen  = bmem_address;
               end
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- one arbitration round ----------------
   task automatic run_round(input bit ireq, input bit dreq, input bit dwr, input bit dboth,
                            input logic [31:0] ia, input logic [31:0] da, input logic [255:0] wline,
                            input int w, input bit exp_first_d, input logic [31:0] exp_a1,
                            input string tag);
      bit   served_i, served_d, cur_d;
      int   steps, exp_step;
      waits     = w;
      served_i  = !ireq;
      served_d  = !dreq;
      cur_d     = exp_first_d;
      last_ref  = cur_d;
      exp_baddr = exp_a1;
      exp_wline = wline;
      icache_read    = ireq;
      icache_address = ia;
      dcache_read    = dreq && (!dwr || dboth);
      dcache_write   = dreq && dwr;
      dcache_address = da;
      dcache_wdata   = wline;
      exp_step = 1 + 4*(w+1);
      steps    = 0;
      while (!(served_i && served_d) && steps < 200) begin
         step();
         steps++;
         if (dreq && dwr && !ireq) check({tag, "_no_read_in_write"}, bmem_read, 1'b0);
         if (icache_resp || dcache_resp) begin
            check({tag, "_resp"}, {icache_resp, dcache_resp}, cur_d ? 2'b01 : 2'b10);
            check({tag, "_latency"}, 256'(steps), 256'(exp_step));
            if (cur_d) begin
               if (dwr) ref_lines[da & ~32'h1F] = wline;
               else     check({tag, "_dcache_rdata"}, dcache_rdata, ref_line(da & ~32'h1F));
               served_d     = 1'b1;
               dcache_read  = 1'b0;
               dcache_write = 1'b0;
            end else begin
               check({tag, "_icache_rdata"}, icache_rdata, ref_line(ia & ~32'h1F));
               served_i    = 1'b1;
               icache_read = 1'b0;
            end
            if (!(served_i && served_d)) begin
               cur_d     = !cur_d;
               last_ref  = cur_d;
               exp_baddr = (cur_d ? da : ia) & ~32'h1F;
               exp_step  = steps + 2 + 4*(w+1);
            end
         end
      end
      if (!(served_i && served_d)) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: served i=%0d d=%0d required both", tag, served_i, served_d);
      end
      icache_read  = 1'b0;
      dcache_read  = 1'b0;
      dcache_write = 1'b0;
      step();
      check({tag, "_resp_single_cycle"}, {icache_resp, dcache_resp}, 2'b00);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_bmem_read"},    bmem_read, 1'b0);
      check({tag, "_bmem_write"},   bmem_write, 1'b0);
      check({tag, "_bmem_address"}, bmem_address, 32'h0);
      check({tag, "_bmem_wdata"},   bmem_wdata, 64'h0);
      check({tag, "_resps"},        {icache_resp, dcache_resp}, 2'b00);
      check({tag, "_icache_rdata"}, icache_rdata, 256'h0);
      check({tag, "_dcache_rdata"}, dcache_rdata, 256'h0);
   endtask

   typedef struct {
      bit           ireq, dreq, dwr, dboth;
      logic [31:0]  ia, da;
      logic [255:0] wline;
      int           w;
      bit           exp_first_d;
      logic [31:0]  exp_a1;
   } vec_t;

   vec_t vecs[8];

   initial begin : main
      logic [255:0] dead_line;
      logic [255:0] l1220;
      logic [255:0] rline;
      bit           ir, dr, dw, db, fd;
      logic [31:0]  ra, rb;

      dead_line = {32'hDEADBEEF, 32'h00000003, 32'hDEADBEEF, 32'h00000002,
                   32'hDEADBEEF, 32'h00000001, 32'hDEADBEEF, 32'h00000000};
      l1220 = {64'h4444444444444444, 64'h3333333333333333,
               64'h2222222222222222, 64'h1111111111111111};
      mem[32'h1220] = 64'h1111111111111111;
      mem[32'h1228] = 64'h2222222222222222;
      mem[32'h1230] = 64'h3333333333333333;
      mem[32'h1238] = 64'h4444444444444444;
      ref_lines[32'h1220] = l1220;

      //            ireq dreq dwr dboth ia            da            wline        w  first_d exp_a1
      vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_2000, 32'h0000_3008, 256'h0,     0, 1'b1, 32'h0000_3000};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_2040, 32'h0000_3040, 256'h0,     1, 1'b1, 32'h0000_3040};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0,         256'h0,     0, 1'b0, 32'h0000_1220};
      vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         32'h8000_0040, dead_line,  2, 1'b1, 32'h8000_0040};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0044, 32'h0,         256'h0,     0, 1'b0, 32'h8000_0040};
      vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0,         32'h0000_4000, ~dead_line, 1, 1'b1, 32'h0000_4000};
      vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_4010, 32'h0,         256'h0,     0, 1'b0, 32'h0000_4000};
      vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_2000, {8{32'h0BADF00D}}, 0, 1'b1, 32'h0000_2000};

      // Reset state
      step();
      step();
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b1;
      step();
      check_reset_outputs("after_reset");

      // Directed table
      for (int i = 0; i < 8; i++) begin
         run_round(vecs[i].ireq, vecs[i].dreq, vecs[i].dwr, vecs[i].dboth, vecs[i].ia, vecs[i].da,
                   vecs[i].wline, vecs[i].w, vecs[i].exp_first_d, vecs[i].exp_a1,
                   $sformatf("vec%0d", i));
      end

      // bmem_resp held high in IDLE and DONE must be ignored
      spurious = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("spurious_idle_resp", {icache_resp, dcache_resp}, 2'b00);
         check("spurious_idle_burst", {bmem_read, bmem_write}, 2'b00);
      end
      run_round(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 256'h0, 1, 1'b0, 32'h0000_1220, "spurious_rd");
      for (int i = 0; i < 3; i++) begin
         step();
         check("spurious_after_resp", {icache_resp, dcache_resp}, 2'b00);
      end
      spurious = 1'b0;

      // Reset in the middle of a read burst, after beat 2 has been accepted
      waits          = 0;
      exp_baddr      = 32'h0000_5000;
      icache_address = 32'h0000_5008;
      icache_read    = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("midburst_no_resp", {icache_resp, dcache_resp}, 2'b00);
      end
      check("midburst_in_read", bmem_read, 1'b1);
      rst = 1'b0;
      #1;
      check_reset_outputs("midburst_reset");
      icache_read = 1'b0;
      step();
      step();
      check_reset_outputs("midburst_reset_held");
      @(negedge clk);
      rst = 1'b1;
      last_ref = 1'b0;
      step();
      check_reset_outputs("midburst_released");
      run_round(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_6018, 32'h0, 256'h0, 0, 1'b0, 32'h0000_6000, "post_reset_rd");

      // Randomized rounds against the reference model
      for (int r = 0; r < 40; r++) begin
         ir = 1'($urandom_range(0, 1));
         dr = 1'($urandom_range(0, 1));
         if (!ir && !dr) ir = 1'b1;
         dw = 1'($urandom_range(0, 1));
         db = dw && ($urandom_range(0, 3) == 0);
         ra = 32'h0001_0000 + 32'($urandom_range(0, 7) * 32) + 32'($urandom_range(0, 31));
         rb = 32'h0001_0000 + 32'($urandom_range(0, 7) * 32) + 32'($urandom_range(0, 31));
         for (int k = 0; k < 8; k++) rline[32*k +: 32] = $urandom;
         fd = (ir && dr) ? !last_ref : dr;
         run_round(ir, dr, dw, db, ra, rb, rline, int'($urandom_range(0, 2)), fd,
                   (fd ? rb : ra) & ~32'h1F, $sformatf("rand%0d", r));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
